fir_filter_s25: RTL and testbench
=================================

# fir_filter_s25

Fixed-coefficient, 16-tap, fully pipelined direct-form FIR filter for signed 24-bit sample streams. It accepts one sample per clock with no handshake. It exposes the full-precision 48-bit accumulator (`sum_stage`) alongside a scaled, saturated 24-bit result (`outputData`). It sits in the sample datapath between the sample source and downstream 24-bit consumers.

## Interface
- `OUT_SHIFT`, default 0: arithmetic right shift applied to `sum_stage` before saturation to 24 bits (range 0–24).
- Coefficients are fixed internal constants, signed 24-bit, symmetric: h[0..15] = 1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1 (sum = 72).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — sole clock; all registers update on the rising edge.
- `reset`  in  1  — asynchronous, active-low; 0 clears all state immediately.
- `inputData`  in  24  — signed sample, consumed every rising edge.
- `outputData`  out  24  — signed, registered; saturate(`sum_stage` >>> `OUT_SHIFT`).
- `sum_stage`  out  48  — signed, registered; full-precision filter sum.

## Operation
- Stage 0: `inputData` is registered into x[0]. A 15-deep delay line shifts each cycle, so x[k] holds the sample from k cycles earlier.
- Stage 1: 16 products p[k] = x[k] * h[k] are computed as 48-bit signed values and registered.
- Stages 2–5: a registered binary adder tree reduces 16 → 8 → 4 → 2 → 1. All sums are 48-bit signed two's complement and wrap modulo 2^48. Wrap cannot occur with the fixed coefficients, since |sum| ≤ 2^23 · 72.
- The final tree register is `sum_stage`.
- Stage 6: `outputData` ← clamp(`sum_stage` >>> `OUT_SHIFT`, −8388608, 8388607). The shift is arithmetic (sign-preserving).
- No valid/ready signalling. The pipeline always advances, and every cycle's input contributes.
- While reset is asserted (0): every register is 0, including the delay line, products, tree, `sum_stage` and `outputData`.
- On reset release, the filter behaves as if all past inputs were 0.
- Reset asserted mid-stream discards all in-flight data immediately (asynchronously). Outputs stay 0 until new samples propagate through.

## Timing
- Edge E0 samples `inputData`.
- Its h[0]-weighted contribution appears on `sum_stage` after E5, a latency of 5 edges.
- It appears on `outputData` after E6, a latency of 6 edges.
- A sample's contribution via tap k appears on `sum_stage` after edge E0 + 5 + k.
- Throughput: 1 sample/cycle.
- `sum_stage` and `outputData` are glitch-free register outputs.
- `outputData` always equals the saturated, scaled value of the `sum_stage` from the previous cycle.
- Reset release: the first rising edge with `reset` = 1 samples normally. Release timing relative to the edge must meet the flops' recovery/removal requirements.

## Test plan
- Reset: hold `reset` = 0 with nonzero input and clock running → `sum_stage` = 0 and `outputData` = 0 throughout. Asserting `reset` = 0 mid-stream forces both to 0 without waiting for a clock edge.
- Impulse: after reset, `inputData` = 1 for exactly one cycle (E0), then 0 → `sum_stage` shows 1, 2, …, 8, 8, …, 2, 1 after edges E5..E20. `outputData` shows the same sequence one cycle later, then 0.
- Step: continuous `inputData` = 1 → `sum_stage` ramps 1, 3, 6, 10, …, and holds at 72 from E20 onward. `outputData` holds at 72 from E21 onward.
- Saturation: continuous `inputData` = 8388607 → `sum_stage` = 603979704 and `outputData` = 8388607. Continuous −8388608 → `sum_stage` = −603979776 and `outputData` = −8388608.
- Sign/scale: continuous `inputData` = −1 with `OUT_SHIFT` = 3 → `sum_stage` = −72 and `outputData` = −9. Continuous +1 with `OUT_SHIFT` = 3 → `outputData` = 9.
- Alternating `inputData` = +1, −1 each cycle → `sum_stage` settles to alternating 0 values (±1·(1−2+3−…) = 0), confirming the tap ordering.

Source files
------------

// File: rtl/fir_filter_s25.sv
// 16-tap symmetric fixed-coefficient FIR, fully pipelined, one sample per clock.
// Exposes the full 48-bit sum and a scaled, saturated 24-bit result.
module fir_filter_s25 #(
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] inputData,
    output logic [23:0] outputData,
    output logic [47:0] sum_stage
);

    localparam int NumTaps = 16;

    // h = 1..8, 8..1
    function automatic logic signed [47:0] coef(input int k);
        return (k < 8) ? 48'(k + 1) : 48'(16 - k);
    endfunction

    logic signed [23:0] x_q    [NumTaps];
    logic signed [47:0] prod_d [NumTaps];
    logic signed [47:0] prod_q [NumTaps];
    logic signed [47:0] l1_d   [8];
    logic signed [47:0] l1_q   [8];
    logic signed [47:0] l2_d   [4];
    logic signed [47:0] l2_q   [4];
    logic signed [47:0] l3_d   [2];
    logic signed [47:0] l3_q   [2];
    logic signed [47:0] sum_d;
    logic signed [47:0] sum_q;
    logic signed [47:0] shifted;
    logic        [23:0] out_d;
    logic        [23:0] out_q;

    // Stage 0: input register and delay line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NumTaps; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            x_q[0] <= $signed(inputData);
            for (int k = 1; k < NumTaps; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    // Stage 1: products, sign-extended to full precision
    always_comb begin
        for (int k = 0; k < NumTaps; k++) begin
            prod_d[k] = 48'(x_q[k]) * coef(k);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NumTaps; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NumTaps; k++) begin
                prod_q[k] <= prod_d[k];
            end
        end
    end

    // Stages 2-5: registered adder tree, wraps modulo 2^48
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            l1_d[i] = prod_q[2*i] + prod_q[2*i+1];
        end
        for (int i = 0; i < 4; i++) begin
            l2_d[i] = l1_q[2*i] + l1_q[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            l3_d[i] = l2_q[2*i] + l2_q[2*i+1];
        end
        sum_d = l3_q[0] + l3_q[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                l1_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                l2_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                l3_q[i] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                l1_q[i] <= l1_d[i];
            end
            for (int i = 0; i < 4; i++) begin
                l2_q[i] <= l2_d[i];
            end
            for (int i = 0; i < 2; i++) begin
                l3_q[i] <= l3_d[i];
            end
            sum_q <= sum_d;
        end
    end

    // Stage 6: arithmetic scale then clamp to the 24-bit signed range
    always_comb begin
        shifted = sum_q >>> OUT_SHIFT;
        if (shifted > 48'sd8388607) begin
            out_d = 24'h7f_ffff;
        end else if (shifted < -48'sd8388608) begin
            out_d = 24'h80_0000;
        end else begin
            out_d = shifted[23:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign sum_stage  = sum_q;
    assign outputData = out_q;

endmodule

// File: tb/tb_fir_filter_s25.sv
// Randomised and directed bench for fir_filter_s25 against a convolution model.
// Two instances share the input stream: OUT_SHIFT = 0 and OUT_SHIFT = 3.
module tb_fir_filter_s25;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] inputData = 24'h123456;
    logic [23:0] out0;
    logic [23:0] out3;
    logic [47:0] sum0;
    logic [47:0] sum3;

    always #5 clk = ~clk;

    fir_filter_s25 #(.OUT_SHIFT(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .inputData  (inputData),
        .outputData (out0),
        .sum_stage  (sum0)
    );

    fir_filter_s25 #(.OUT_SHIFT(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .inputData  (inputData),
        .outputData (out3),
        .sum_stage  (sum3)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    // hist[0] is the sample taken at the latest edge, hist[j] j edges earlier
    longint hist [21];
    longint exp_sum;
    longint exp_out0;
    longint exp_out3;

    function automatic longint tap(input int k);
        return (k < 8) ? longint'(k + 1) : longint'(16 - k);
    endfunction

    // Sum after edge n uses the sample from edge n-5-k on tap k
    function automatic longint conv();
        longint acc = 0;
        for (int k = 0; k < 16; k++) begin
            acc += tap(k) * hist[5+k];
        end
        return acc;
    endfunction

    function automatic longint sat(input longint v, input int sh);
        longint s = v >>> sh;
        if (s > 8388607)  return 8388607;
        if (s < -8388608) return -8388608;
        return s;
    endfunction

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint s48(input logic [47:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint s24(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 21; i++) begin
            hist[i] = 0;
        end
        exp_sum  = 0;
        exp_out0 = 0;
        exp_out3 = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_sum0"}, s48(sum0), exp_sum);
        check_eq({tag, "_sum3"}, s48(sum3), exp_sum);
        check_eq({tag, "_out0"}, s24(out0), exp_out0);
        check_eq({tag, "_out3"}, s24(out3), exp_out3);
    endtask

    task automatic drive(input longint s, input string tag);
        @(negedge clk);
        inputData = 24'(s);
        @(posedge clk);
        if (reset) begin
            for (int i = 20; i > 0; i--) begin
                hist[i] = hist[i-1];
            end
            hist[0]  = s;
            exp_out0 = sat(exp_sum, 0);
            exp_out3 = sat(exp_sum, 3);
            exp_sum  = conv();
        end else begin
            clear_model();
        end
        #1;
        check_all(tag);
    endtask

    // Asserts reset between edges, checks outputs clear without a clock edge
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        clear_model();
        check_all("rst_async");
        for (int i = 0; i < 3; i++) begin
            drive(longint'($urandom_range(1, 8000000)), "rst_hold");
        end
        reset = 1'b1;
    endtask

    function automatic longint rand24();
        logic [23:0] r;
        r = 24'($urandom);
        case ($urandom_range(0, 7))
            0:       return 8388607;
            1:       return -8388608;
            default: return s24(r);
        endcase
    endfunction

    initial begin
        clear_model();
        #1;
        check_all("rst_init");
        for (int i = 0; i < 4; i++) begin
            drive(longint'($urandom_range(1, 8000000)), "rst_hold");
        end
        reset = 1'b1;

        // Impulse
        drive(1, "imp");
        for (int i = 0; i < 5; i++) begin
            drive(0, "imp");
        end
        check_eq("imp_e5_sum", s48(sum0), 1);
        drive(0, "imp");
        check_eq("imp_e6_sum", s48(sum0), 2);
        check_eq("imp_e6_out", s24(out0), 1);
        for (int i = 0; i < 16; i++) begin
            drive(0, "imp");
        end

        // Step
        async_reset();
        for (int i = 0; i < 21; i++) begin
            drive(1, "step");
        end
        check_eq("step_sum72", s48(sum0), 72);
        drive(1, "step");
        check_eq("step_out72", s24(out0), 72);
        check_eq("step_out3", s24(out3), 9);

        // Positive saturation
        async_reset();
        for (int i = 0; i < 22; i++) begin
            drive(8388607, "satp");
        end
        check_eq("satp_sum", s48(sum0), 603979704);
        check_eq("satp_out", s24(out0), 8388607);

        // Negative saturation
        async_reset();
        for (int i = 0; i < 22; i++) begin
            drive(-8388608, "satn");
        end
        check_eq("satn_sum", s48(sum0), -603979776);
        check_eq("satn_out", s24(out0), -8388608);

        // Sign and scale
        async_reset();
        for (int i = 0; i < 22; i++) begin
            drive(-1, "neg1");
        end
        check_eq("neg1_sum", s48(sum3), -72);
        check_eq("neg1_out3", s24(out3), -9);

        // Alternating +1/-1 cancels across the symmetric taps
        for (int i = 0; i < 30; i++) begin
            drive((i % 2 == 0) ? 1 : -1, "alt");
        end
        check_eq("alt_sum_a", s48(sum0), 0);
        drive(1, "alt");
        check_eq("alt_sum_b", s48(sum0), 0);

        // Random stream with a mid-stream reset
        for (int i = 0; i < 300; i++) begin
            drive(rand24(), "rand");
            if (i == 150) begin
                async_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
